// File: rtl/uart_pkg.sv
// Constants shared by the UART receive- and transmit-side framing logic.
package uart_pkg;
  localparam logic [7:0] UART_FRAME_CHAR = 8'h26;
  localparam logic [1:0] ERR_OVF         = 2'b01;
  localparam logic [1:0] ERR_TMO         = 2'b10;
endpackage

// File: rtl/uart_frame_rx_if.sv
// Byte-in / frame-status bus of the UART frame receiver.
interface uart_frame_rx_if;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] frame_len;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       rx_busy;

  modport master (output rx_data, rx_vld, rd_addr,
                  input  rd_data, frame_len, frame_done, frame_err, err_code, rx_busy);
  modport slave  (input  rx_data, rx_vld, rd_addr,
                  output rd_data, frame_len, frame_done, frame_err, err_code, rx_busy);
endinterface

// File: rtl/uart_frame_rx_frame_ram.sv
// Payload buffer: simple dual-port, synchronous write, registered read.
module frame_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) rdata_q <= '0;
    else          rdata_q <= mem_q[raddr_i];

  assign rdata_o = rdata_q;
endmodule

// File: rtl/uart_frame_rx.sv
// Extracts "&&payload&&" frames from a UART byte stream into a readable buffer;
// a lone '&' inside the payload is escaped by any following non-'&' byte.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int MAX_LEN     = 64,
  parameter int TIMEOUT_CLK = 50_000
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  uart_frame_rx_if.slave bus
);
  localparam int AW = 6;
  localparam int TW = $clog2(TIMEOUT_CLK);

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    SOF1    = 6'b000010,
    PAYLOAD = 6'b000100,
    EOF1    = 6'b001000,
    DONE    = 6'b010000,
    ERR     = 6'b100000
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    wcnt_q, wcnt_d, len_q, len_d, pdat_q, pdat_d;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [1:0]    err_q, err_d;
  logic          pend_q, pend_d;
  logic          we, amp, busy, tmo_hit;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata, wcnt_m1;

  assign amp     = bus.rx_vld && (bus.rx_data == UART_FRAME_CHAR);
  assign busy    = (state_q == SOF1) || (state_q == PAYLOAD) || (state_q == EOF1);
  assign tmo_inc = tmo_q + TW'(1);
  assign tmo_hit = (tmo_inc == TW'(TIMEOUT_CLK - 1));
  assign wcnt_m1 = wcnt_q - 8'd1;

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      tmo_q   <= '0;
      len_q   <= '0;
      err_q   <= '0;
      pend_q  <= 1'b0;
      pdat_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
      len_q   <= len_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      pdat_q  <= pdat_d;
    end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tmo_d   = '0;
    len_d   = len_q;
    err_d   = err_q;
    pend_d  = 1'b0;
    pdat_d  = pdat_q;
    we      = 1'b0;
    waddr   = wcnt_q[AW-1:0];
    wdata   = bus.rx_data;

    // Second half of an escaped pair; wcnt already advanced by two.
    if (pend_q) begin
      we    = 1'b1;
      waddr = wcnt_m1[AW-1:0];
      wdata = pdat_q;
    end

    if (busy) tmo_d = bus.rx_vld ? '0 : tmo_inc;

    case (state_q)
      SOF1:
        if (amp) begin
          state_d = PAYLOAD;
          wcnt_d  = '0;
        end else if (bus.rx_vld) state_d = IDLE;
      PAYLOAD:
        if (amp) state_d = EOF1;
        else if (bus.rx_vld) begin
          if (wcnt_q >= 8'(MAX_LEN)) begin
            state_d = ERR;
            err_d   = ERR_OVF;
          end else begin
            we     = 1'b1;
            waddr  = wcnt_q[AW-1:0];
            wdata  = bus.rx_data;
            wcnt_d = wcnt_q + 8'd1;
          end
        end
      EOF1:
        if (amp) state_d = DONE;
        else if (bus.rx_vld) begin
          if (wcnt_q >= 8'(MAX_LEN - 1)) begin
            state_d = ERR;
            err_d   = ERR_OVF;
          end else begin
            we      = 1'b1;
            waddr   = wcnt_q[AW-1:0];
            wdata   = UART_FRAME_CHAR;
            pend_d  = 1'b1;
            pdat_d  = bus.rx_data;
            wcnt_d  = wcnt_q + 8'd2;
            state_d = PAYLOAD;
          end
        end
      DONE: begin
        len_d   = wcnt_q;
        state_d = amp ? SOF1 : IDLE;
      end
      default: state_d = amp ? SOF1 : IDLE;
    endcase

    if (busy && !bus.rx_vld && tmo_hit) begin
      state_d = ERR;
      err_d   = ERR_TMO;
      tmo_d   = '0;
    end
  end

  frame_ram #(.DEPTH(MAX_LEN), .AW(AW)) u_ram (
    .clk_i   (sys_clk),
    .rst_n_i (sys_rst_n),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (bus.rd_addr),
    .rdata_o (bus.rd_data)
  );

  assign bus.frame_len  = len_q;
  assign bus.frame_done = (state_q == DONE);
  assign bus.frame_err  = (state_q == ERR);
  assign bus.err_code   = err_q;
  assign bus.rx_busy    = busy;
endmodule
